mc_control_unit: RTL and testbench

- Multi-cycle main controller for the RV32 core.
- Sequences the shared ALU, register file, instruction register (IR) and unified memory port through fetch/decode/execute/writeback states.
- Produces the `ALUOp[1:0]` code consumed by `alu_control`, plus all datapath mux selects and write enables.
- Counts retired instructions.

---
 rtl/mc_control_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit
// Purpose  : Multi-cycle main controller for the RV32 core. Sequences the
//            shared ALU, register file, instruction register and unified
//            memory port through fetch / decode / execute / writeback, and
//            counts retired instructions.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            opcode[6:0]         - IR[6:0], stable from DECODE onward
//            zero                - ALU zero flag (branch condition)
//            mem_ready           - memory completes the access this cycle
//            mem_req/mem_we/iord - memory request, write, address select
//            ir_write/pc_write   - IR and PC load enables
//            reg_write           - register file write enable
//            alu_src_a/b         - ALU operand selects
//            result_src          - result mux select
//            ALUOp[1:0]          - code for alu_control
//            illegal             - sticky unsupported-opcode flag
//            instret[CNT_W-1:0]  - retired-instruction count
//            state_o[3:0]        - current state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    EXEC_R  = 4'd6,
    EXEC_I  = 4'd7,
    ALU_WB  = 4'd8,
    BRANCH  = 4'd9,
    TRAP    = 4'd10
  } state_e;

  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  // Moore control bundle. The two PC-write sources are kept apart because
  // each is qualified by a different input (mem_ready vs. zero).
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write_fetch;
    logic       pc_write_br;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req        = 1'b1;
        c.ir_write       = 1'b1;
        c.pc_write_fetch = 1'b1;
        c.alu_src_a      = 2'b00;
        c.alu_src_b      = 2'b10;
        c.alu_op         = 2'b00;
        c.result_src     = 2'b10;
      end
      DECODE: begin
        // oldPC + imm lands in ALUOut as the branch target
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
      end
      MEM_ADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
      end
      MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.result_src = 2'b01;
      end
      MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      EXEC_R: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
      end
      EXEC_I: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      ALU_WB: begin
        c.reg_write  = 1'b1;
        c.result_src = 2'b00;
      end
      BRANCH: begin
        c.alu_src_a   = 2'b10;
        c.alu_src_b   = 2'b00;
        c.alu_op      = 2'b01;
        c.result_src  = 2'b00;
        c.pc_write_br = 1'b1;
      end
      TRAP: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e            state_q, state_d;
  ctrl_t             ctrl_q;
  logic [CNT_W-1:0]  instret_q;
  logic              retire_d;

  // Next-state logic. mem_ready is only consulted in the three states that
  // own a memory access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          c_op_rtype:           state_d = EXEC_R;
          c_op_itype:           state_d = EXEC_I;
          c_op_load,
          c_op_store:           state_d = MEM_ADR;
          c_op_branch:          state_d = BRANCH;
          default:              state_d = TRAP;
        endcase
      end
      MEM_ADR: state_d = (opcode == c_op_load) ? MEM_RD : MEM_WR;
      MEM_RD:  if (mem_ready) state_d = MEM_WB;
      MEM_WB:  state_d = FETCH;
      MEM_WR:  if (mem_ready) state_d = FETCH;
      EXEC_R:  state_d = ALU_WB;
      EXEC_I:  state_d = ALU_WB;
      ALU_WB:  state_d = FETCH;
      BRANCH:  state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire_d = 1'b0;
    case (state_q)
      MEM_WB, ALU_WB, BRANCH: retire_d = 1'b1;
      MEM_WR:                 retire_d = mem_ready;
      default:                retire_d = 1'b0;
    endcase
  end

  // State, counter and registered control bundle. The bundle is decoded
  // from the next state so it is valid in the same cycle as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ctrl_q    <= decode_ctrl(FETCH);
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
      if (retire_d) begin
        instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Reset forces every control output low combinationally so nothing is
  // issued (or written) on a cycle where rst_n is sampled low.
  assign mem_req    = rst_n & ctrl_q.mem_req;
  assign mem_we     = rst_n & ctrl_q.mem_we;
  assign iord       = rst_n & ctrl_q.iord;
  assign ir_write   = rst_n & ctrl_q.ir_write & mem_ready;
  assign pc_write   = rst_n & ((ctrl_q.pc_write_fetch & mem_ready) |
                               (ctrl_q.pc_write_br & zero));
  assign reg_write  = rst_n & ctrl_q.reg_write;
  assign alu_src_a  = rst_n ? ctrl_q.alu_src_a  : 2'b00;
  assign alu_src_b  = rst_n ? ctrl_q.alu_src_b  : 2'b00;
  assign result_src = rst_n ? ctrl_q.result_src : 2'b00;
  assign ALUOp      = rst_n ? ctrl_q.alu_op     : 2'b00;
  assign illegal    = rst_n & ctrl_q.illegal;
  assign instret    = instret_q;
  assign state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_unit
// Purpose  : Self-checking bench for mc_control_unit. Each instruction is
//            expanded into its expected per-cycle state trace from its
//            opcode class and memory wait counts; outputs are compared
//            against the per-state output table every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADR = 2, S_MEM_RD = 3,
                 S_MEM_WB = 4, S_MEM_WR = 5, S_EXEC_R = 6, S_EXEC_I = 7,
                 S_ALU_WB = 8, S_BRANCH = 9, S_TRAP = 10;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src, ALUOp;
  logic        illegal;
  logic [31:0] instret;
  logic [3:0]  state_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_instret = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .ALUOp(ALUOp), .illegal(illegal), .instret(instret), .state_o(state_o)
  );

  // Expected outputs for a state, packed as
  // {mem_req, mem_we, iord, ir_write, pc_write, reg_write,
  //  alu_src_a, alu_src_b, result_src, ALUOp, illegal}
  function automatic logic [14:0] exp_ctrl(input int st, input logic rdy,
                                           input logic z, input logic rstn);
    logic       mr, mw, io, irw, pcw, rw, il;
    logic [1:0] a, b, rs, op;
    mr = 0; mw = 0; io = 0; irw = 0; pcw = 0; rw = 0; il = 0;
    a = 0; b = 0; rs = 0; op = 0;
    if (rstn) begin
      case (st)
        S_FETCH:   begin mr = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
        S_DECODE:  begin a = 2'b01; b = 2'b01; end
        S_MEM_ADR: begin a = 2'b10; b = 2'b01; end
        S_MEM_RD:  begin mr = 1; io = 1; end
        S_MEM_WB:  begin rw = 1; rs = 2'b01; end
        S_MEM_WR:  begin mr = 1; mw = 1; io = 1; end
        S_EXEC_R:  begin a = 2'b10; op = 2'b10; end
        S_EXEC_I:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
        S_ALU_WB:  begin rw = 1; end
        S_BRANCH:  begin a = 2'b10; op = 2'b01; pcw = z; end
        S_TRAP:    begin il = 1; end
        default:   ;
      endcase
    end
    return {mr, mw, io, irw, pcw, rw, a, b, rs, op, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, then advance.
  task automatic cyc(input int st, input logic rdy, input logic z,
                     input logic rstn, input logic retire);
    logic [14:0] got;
    mem_ready = rdy;
    zero      = z;
    rst_n     = rstn;
    @(negedge clk);
    got = {mem_req, mem_we, iord, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, ALUOp, illegal};
    chk($sformatf("ctrl@st%0d", st), {17'd0, got}, {17'd0, exp_ctrl(st, rdy, z, rstn)});
    chk("state", {28'd0, state_o}, st);
    chk("instret", instret, exp_instret);
    @(posedge clk);
    if (!rstn)       exp_instret = 0;
    else if (retire) exp_instret = exp_instret + 1;
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected trace of a whole instruction derived from its opcode class.
  // fw = FETCH wait cycles, mw = data-memory wait cycles, tl = cycles in
  // TRAP before a one-edge reset recovers the core.
  task automatic run_instr(input logic [6:0] opc, input logic z,
                           input int fw, input int mw, input int tl);
    opcode = opc;
    for (int i = 0; i < fw; i++) cyc(S_FETCH, 1'b0, rb(), 1'b1, 1'b0);
    cyc(S_FETCH, 1'b1, rb(), 1'b1, 1'b0);
    cyc(S_DECODE, rb(), rb(), 1'b1, 1'b0);
    case (opc)
      OP_R: begin
        cyc(S_EXEC_R, rb(), rb(), 1'b1, 1'b0);
        cyc(S_ALU_WB, rb(), rb(), 1'b1, 1'b1);
      end
      OP_I: begin
        cyc(S_EXEC_I, rb(), rb(), 1'b1, 1'b0);
        cyc(S_ALU_WB, rb(), rb(), 1'b1, 1'b1);
      end
      OP_LD: begin
        cyc(S_MEM_ADR, rb(), rb(), 1'b1, 1'b0);
        for (int i = 0; i < mw; i++) cyc(S_MEM_RD, 1'b0, rb(), 1'b1, 1'b0);
        cyc(S_MEM_RD, 1'b1, rb(), 1'b1, 1'b0);
        cyc(S_MEM_WB, rb(), rb(), 1'b1, 1'b1);
      end
      OP_ST: begin
        cyc(S_MEM_ADR, rb(), rb(), 1'b1, 1'b0);
        for (int i = 0; i < mw; i++) cyc(S_MEM_WR, 1'b0, rb(), 1'b1, 1'b0);
        cyc(S_MEM_WR, 1'b1, rb(), 1'b1, 1'b1);
      end
      OP_BR: cyc(S_BRANCH, rb(), z, 1'b1, 1'b1);
      default: begin
        for (int i = 0; i < tl; i++) cyc(S_TRAP, rb(), rb(), 1'b1, 1'b0);
        cyc(S_TRAP, rb(), rb(), 1'b0, 1'b0);
      end
    endcase
  endtask

  function automatic logic [6:0] rand_illegal();
    logic [6:0] o;
    do o = 7'($urandom);
    while (o == OP_R || o == OP_I || o == OP_LD || o == OP_ST || o == OP_BR);
    return o;
  endfunction

  initial begin
    rst_n     = 1'b0;
    opcode    = 7'($urandom);
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Still in reset with mem_ready high: no request may be issued.
    cyc(S_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);

    // R-type, zero waits: 0,1,6,8
    run_instr(OP_R, 1'b0, 0, 0, 0);
    // Load with two MEM_RD waits: 0,1,2,3,3,3,4
    run_instr(OP_LD, 1'b0, 0, 2, 0);
    // Branch taken then not taken
    run_instr(OP_BR, 1'b1, 0, 0, 0);
    run_instr(OP_BR, 1'b0, 0, 0, 0);
    // Store with fetch delayed three cycles
    run_instr(OP_ST, 1'b0, 3, 0, 0);
    run_instr(OP_I, 1'b0, 1, 0, 0);
    // Unsupported opcode: 20 cycles in TRAP, then reset
    run_instr(7'b1111111, 1'b0, 0, 0, 20);
    run_instr(OP_R, 1'b0, 0, 0, 0);

    // Reset during MEM_RD while memory is ready: the load is abandoned.
    opcode = OP_LD;
    cyc(S_FETCH, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(S_DECODE, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(S_MEM_ADR, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(S_MEM_RD, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(S_MEM_RD, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(OP_ST, 1'b1, 0, 1, 0);

    // Randomized instruction mix
    for (int n = 0; n < 80; n++) begin
      int k;
      logic [6:0] o;
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    o = OP_R;
        2, 3:    o = OP_I;
        4:       o = OP_LD;
        5:       o = OP_ST;
        6, 7:    o = OP_BR;
        default: o = (k == 8) ? rand_illegal() : OP_LD;
      endcase
      run_instr(o, rb(), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(1, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
